// File: rtl/rv32i_core.sv
// Single-cycle RV32I core: combinational fetch/decode/execute/memory, with state
// committed at each rising edge. Holds a halted state until reset.

module register_file (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_idx,
  input  logic [4:0]  rs2_idx,
  input  logic [4:0]  rd_idx,
  input  logic        we,
  input  logic [31:0] rd_data,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data
);
  logic [31:0] mem [0:31];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (we && (rd_idx != 5'd0)) begin
      mem[rd_idx] <= rd_data;
    end
  end

  assign rs1_data = (rs1_idx == 5'd0) ? 32'd0 : mem[rs1_idx];
  assign rs2_data = (rs2_idx == 5'd0) ? 32'd0 : mem[rs2_idx];
endmodule

module rv32i_core (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] op_inst_addr,
  input  logic        ip_inst_valid,
  input  logic [31:0] ip_inst_from_imem,
  output logic [31:0] op_data_addr,
  output logic        op_data_wr,
  output logic [3:0]  op_data_mask,
  output logic [31:0] op_data_from_proc,
  output logic        op_data_rd,
  input  logic        ip_data_valid,
  input  logic [31:0] ip_data_from_dmem
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0] pc;
  logic        halted;
  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;
  logic signed [31:0] rs1_s, rs2_s;
  logic [31:0] pc_plus4, next_pc, rd_val;
  logic        rd_we, is_load, is_store, take;
  logic        imm_ok, reg_ok;
  logic        halt_now, active, stall, reg_we;

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] r;
    sa = a;
    sb = b;
    r  = '0;
    case (f3)
      3'd0: r = alt ? (a - b) : (a + b);
      3'd1: r = a << b[4:0];
      3'd2: r = {31'd0, (sa < sb)};
      3'd3: r = {31'd0, (a < b)};
      3'd4: r = a ^ b;
      3'd5: r = alt ? $unsigned(sa >>> b[4:0]) : (a >> b[4:0]);
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {off, 3'b000};
    case (f3)
      3'd0:    r = {{24{sh[7]}}, sh[7:0]};
      3'd1:    r = {{16{sh[15]}}, sh[15:0]};
      3'd4:    r = {24'd0, sh[7:0]};
      3'd5:    r = {16'd0, sh[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    case (f3)
      3'd0:    m = 4'b0001 << off;
      3'd1:    m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] store_lane(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3)
      3'd0:    r = {4{d[7:0]}};
      3'd1:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  assign inst     = ip_inst_from_imem;
  assign opcode   = inst[6:0];
  assign funct3   = inst[14:12];
  assign funct7   = inst[31:25];
  assign imm_i    = {{20{inst[31]}}, inst[31:20]};
  assign imm_s    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u    = {inst[31:12], 12'd0};
  assign imm_j    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign rs1_s    = rs1_val;
  assign rs2_s    = rs2_val;
  assign pc_plus4 = pc + 32'd4;

  register_file register_file_0 (
    .clk      (clk),
    .reset    (reset),
    .rs1_idx  (inst[19:15]),
    .rs2_idx  (inst[24:20]),
    .rd_idx   (inst[11:7]),
    .we       (reg_we),
    .rd_data  (rd_val),
    .rs1_data (rs1_val),
    .rs2_data (rs2_val)
  );

  // Shift immediates and R-type funct7 must be legal; anything else falls to NOP.
  assign imm_ok = (funct3 == 3'd1) ? (funct7 == 7'h00) :
                  (funct3 == 3'd5) ? ((funct7 == 7'h00) || (funct7 == 7'h20)) : 1'b1;
  assign reg_ok = (funct7 == 7'h00) ||
                  ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));

  always_comb begin
    next_pc  = pc_plus4;
    rd_we    = 1'b0;
    rd_val   = '0;
    is_load  = 1'b0;
    is_store = 1'b0;
    take     = 1'b0;
    case (opcode)
      OP_LUI: begin
        rd_we  = 1'b1;
        rd_val = imm_u;
      end
      OP_AUIPC: begin
        rd_we  = 1'b1;
        rd_val = pc + imm_u;
      end
      OP_JAL: begin
        rd_we   = 1'b1;
        rd_val  = pc_plus4;
        next_pc = pc + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'd0) begin
          rd_we   = 1'b1;
          rd_val  = pc_plus4;
          next_pc = (rs1_val + imm_i) & ~32'd1;
        end
      end
      OP_BRANCH: begin
        case (funct3)
          3'd0:    take = (rs1_val == rs2_val);
          3'd1:    take = (rs1_val != rs2_val);
          3'd4:    take = (rs1_s < rs2_s);
          3'd5:    take = (rs1_s >= rs2_s);
          3'd6:    take = (rs1_val < rs2_val);
          3'd7:    take = (rs1_val >= rs2_val);
          default: take = 1'b0;
        endcase
        if (take) next_pc = pc + imm_b;
      end
      OP_LOAD: begin
        if ((funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7)) begin
          is_load = 1'b1;
          rd_we   = 1'b1;
          rd_val  = load_ext(funct3, op_data_addr[1:0], ip_data_from_dmem);
        end
      end
      OP_STORE: begin
        if (funct3 < 3'd3) is_store = 1'b1;
      end
      OP_IMM: begin
        if (imm_ok) begin
          rd_we  = 1'b1;
          rd_val = alu(funct3, (funct3 == 3'd5) && inst[30], rs1_val, imm_i);
        end
      end
      OP_REG: begin
        if (reg_ok) begin
          rd_we  = 1'b1;
          rd_val = alu(funct3, inst[30], rs1_val, rs2_val);
        end
      end
      default: ;
    endcase
  end

  assign halt_now = halted || !ip_inst_valid || (inst == 32'd0);
  assign active   = !reset && !halt_now;
  assign stall    = is_load && !ip_data_valid;
  assign reg_we   = active && rd_we && !stall;

  assign op_inst_addr      = pc;
  assign op_data_addr      = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign op_data_rd        = active && is_load;
  assign op_data_wr        = active && is_store;
  assign op_data_mask      = (active && is_store) ? store_mask(funct3, op_data_addr[1:0]) : 4'b0000;
  assign op_data_from_proc = store_lane(funct3, rs2_val);

  // Commit boundary: PC and halt state advance together with the register write.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= '0;
      halted <= 1'b0;
    end else if (halt_now) begin
      halted <= 1'b1;
    end else if (!stall) begin
      pc <= next_pc;
    end
  end
endmodule

// File: tb/tb_rv32i_core.sv
// Directed program-level bench for rv32i_core with local imem/dmem models.

module tb_rv32i_core;
  logic        clk;
  logic        reset;
  logic [31:0] op_inst_addr;
  logic        ip_inst_valid;
  logic [31:0] ip_inst_from_imem;
  logic [31:0] op_data_addr;
  logic        op_data_wr;
  logic [3:0]  op_data_mask;
  logic [31:0] op_data_from_proc;
  logic        op_data_rd;
  logic        ip_data_valid;
  logic [31:0] ip_data_from_dmem;

  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:15];
  logic        ivalid, dvalid, dmem_clr;
  int          n_w;
  int          vectors, miscompares;

  rv32i_core dut (
    .clk               (clk),
    .reset             (reset),
    .op_inst_addr      (op_inst_addr),
    .ip_inst_valid     (ip_inst_valid),
    .ip_inst_from_imem (ip_inst_from_imem),
    .op_data_addr      (op_data_addr),
    .op_data_wr        (op_data_wr),
    .op_data_mask      (op_data_mask),
    .op_data_from_proc (op_data_from_proc),
    .op_data_rd        (op_data_rd),
    .ip_data_valid     (ip_data_valid),
    .ip_data_from_dmem (ip_data_from_dmem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ip_inst_from_imem = imem[op_inst_addr[7:2]];
  assign ip_inst_valid     = ivalid && (op_inst_addr[31:8] == 24'd0);
  assign ip_data_from_dmem = dmem[op_data_addr[5:2]];
  assign ip_data_valid     = dvalid;

  always @(posedge clk) begin
    if (dmem_clr) begin
      for (int i = 0; i < 16; i++) dmem[i] <= '0;
    end else if (op_data_wr) begin
      for (int b = 0; b < 4; b++)
        if (op_data_mask[b]) dmem[op_data_addr[5:2]][8*b +: 8] <= op_data_from_proc[8*b +: 8];
    end
  end

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    logic [31:0] im = imm, a = rs1, f = f3, d = rd, o = op;
    return {im[11:0], a[4:0], f[2:0], d[4:0], o[6:0]};
  endfunction

  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return enc_i(imm, rs1, 0, rd, 7'h13);
  endfunction

  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    logic [31:0] im = imm, b = rs2, a = rs1, f = f3;
    return {im[11:5], b[4:0], a[4:0], f[2:0], im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    logic [31:0] im = imm, b = rs2, a = rs1, f = f3;
    return {im[12], im[10:5], b[4:0], a[4:0], f[2:0], im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    logic [31:0] s = f7, b = rs2, a = rs1, f = f3, d = rd;
    return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'h33};
  endfunction

  function automatic logic [31:0] enc_j(int rd, int imm);
    logic [31:0] im = imm, d = rd;
    return {im[20], im[10:1], im[11], im[19:12], d[4:0], 7'h6f};
  endfunction

  function automatic logic [31:0] enc_u(int rd, int imm, int op);
    logic [31:0] im = imm, d = rd, o = op;
    return {im[19:0], d[4:0], o[6:0]};
  endfunction

  function automatic logic [31:0] xr(int i);
    return dut.register_file_0.mem[i];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic prog_clear();
    for (int i = 0; i < 64; i++) imem[i] = 32'd0;
    n_w = 0;
  endtask

  task automatic emit(input logic [31:0] w);
    imem[n_w] = w;
    n_w++;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    dmem_clr = 1'b1;
    run(2);
    reset    = 1'b0;
    dmem_clr = 1'b0;
  endtask

  task automatic load_mem_prog(input int val);
    prog_clear();
    emit(addi(1, 0, val));
    emit(enc_s(1, 1, 0, 0));    // SB x1,1(x0)
    emit(enc_i(0, 0, 2, 2, 3)); // LW x2,0(x0)
    emit(enc_i(1, 0, 0, 3, 3)); // LB x3,1(x0)
    emit(enc_i(1, 0, 4, 4, 3)); // LBU x4,1(x0)
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    ivalid = 1'b1;
    dvalid = 1'b1;
    reset = 1'b1;
    dmem_clr = 1'b1;

    // BEQ taken, then halt
    prog_clear();
    emit(addi(1, 0, 5));
    emit(addi(2, 0, 5));
    emit(enc_b(8, 2, 1, 0));
    emit(addi(3, 0, 1));
    emit(addi(4, 0, 7));
    @(negedge clk);
    check("reset_pc", op_inst_addr, 32'd0);
    check("reset_wr", {31'd0, op_data_wr}, 32'd0);
    check("reset_rd", {31'd0, op_data_rd}, 32'd0);
    check("reset_x1", xr(1), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dmem_clr = 1'b0;
    run(10);
    check("beq_x3", xr(3), 32'd0);
    check("beq_x4", xr(4), 32'd7);
    check("halt_pc", op_inst_addr, 32'd20);
    run(3);
    check("halt_frozen", op_inst_addr, 32'd20);

    // BNE not taken
    prog_clear();
    emit(addi(1, 0, 5));
    emit(addi(2, 0, 5));
    emit(enc_b(8, 2, 1, 1));
    emit(addi(3, 0, 1));
    do_reset();
    run(6);
    check("bne_x3", xr(3), 32'd1);

    // Signed vs unsigned branches
    prog_clear();
    emit(addi(1, 0, -1));
    emit(addi(2, 0, 1));
    emit(enc_b(8, 2, 1, 4));  // BLT taken
    emit(addi(3, 0, 1));
    emit(addi(4, 0, 2));
    emit(enc_b(8, 2, 1, 6));  // BLTU not taken
    emit(addi(5, 0, 3));
    emit(addi(6, 0, 4));
    emit(enc_b(8, 2, 1, 7));  // BGEU taken
    emit(addi(7, 0, 5));
    emit(addi(8, 0, 6));
    do_reset();
    run(12);
    check("blt_skip_x3", xr(3), 32'd0);
    check("blt_tgt_x4", xr(4), 32'd2);
    check("bltu_fall_x5", xr(5), 32'd3);
    check("bltu_next_x6", xr(6), 32'd4);
    check("bgeu_skip_x7", xr(7), 32'd0);
    check("bgeu_tgt_x8", xr(8), 32'd6);

    // Backward loop: 1 setup + 6 loop + 1 exit
    prog_clear();
    emit(addi(1, 0, 3));
    emit(addi(1, 1, -1));
    emit(enc_b(-4, 0, 1, 1));
    do_reset();
    run(6);
    check("loop_pc6", op_inst_addr, 32'd8);
    check("loop_x1", xr(1), 32'd0);
    run(1);
    check("loop_pc7", op_inst_addr, 32'd12);

    // Byte store / loads with a load stall
    load_mem_prog(32'h7F);
    do_reset();
    run(1);
    check("sb_wr", {31'd0, op_data_wr}, 32'd1);
    check("sb_mask", {28'd0, op_data_mask}, 32'h2);
    check("sb_data", op_data_from_proc, 32'h7F7F7F7F);
    check("sb_addr", op_data_addr, 32'd1);
    run(1);
    dvalid = 1'b0;
    #1;
    check("lw_rd", {31'd0, op_data_rd}, 32'd1);
    check("lw_mask", {28'd0, op_data_mask}, 32'd0);
    run(1);
    check("stall_pc", op_inst_addr, 32'd8);
    check("stall_x2", xr(2), 32'd0);
    check("stall_rd_held", {31'd0, op_data_rd}, 32'd1);
    dvalid = 1'b1;
    run(4);
    check("lw_x2", xr(2), 32'h00007F00);
    check("lb_x3", xr(3), 32'h0000007F);
    check("lbu_x4", xr(4), 32'h0000007F);

    // Negative byte, halfword store/load
    load_mem_prog(32'h80);
    emit(enc_s(2, 1, 0, 1));    // SH x1,2(x0)
    emit(enc_i(2, 0, 1, 5, 3)); // LH x5,2(x0)
    emit(enc_i(0, 0, 2, 6, 3)); // LW x6,0(x0)
    do_reset();
    run(5);
    check("sh_mask", {28'd0, op_data_mask}, 32'hC);
    check("sh_data", op_data_from_proc, 32'h00800080);
    run(4);
    check("lw80_x2", xr(2), 32'h00008000);
    check("lb80_x3", xr(3), 32'hFFFFFF80);
    check("lbu80_x4", xr(4), 32'h00000080);
    check("lh_x5", xr(5), 32'h00000080);
    check("lw_sh_x6", xr(6), 32'h00808000);

    // R-type, LUI, JAL, x0 write
    prog_clear();
    emit(addi(1, 0, -16));
    emit(addi(2, 0, 2));
    emit(enc_r(7'h20, 2, 1, 5, 3));
    emit(enc_r(7'h00, 2, 1, 5, 4));
    emit(enc_r(7'h20, 1, 2, 0, 5));
    emit(enc_r(7'h00, 2, 1, 2, 6));
    emit(enc_r(7'h00, 2, 1, 3, 7));
    emit(enc_u(8, 32'h12345, 7'h37));
    emit(addi(0, 0, 9));
    emit(enc_j(9, 8));
    emit(addi(10, 0, 1));
    do_reset();
    run(12);
    check("sra_x3", xr(3), 32'hFFFFFFFC);
    check("srl_x4", xr(4), 32'h3FFFFFFC);
    check("sub_x5", xr(5), 32'd18);
    check("slt_x6", xr(6), 32'd1);
    check("sltu_x7", xr(7), 32'd0);
    check("lui_x8", xr(8), 32'h12345000);
    check("x0_mem0", xr(0), 32'd0);
    check("jal_x9", xr(9), 32'd40);
    check("jal_skip_x10", xr(10), 32'd0);
    check("jal_pc", op_inst_addr, 32'd44);

    // Invalid fetch halts until reset
    prog_clear();
    emit(addi(1, 0, 5));
    emit(addi(2, 0, 5));
    emit(addi(3, 0, 1));
    do_reset();
    run(1);
    ivalid = 1'b0;
    run(1);
    ivalid = 1'b1;
    run(4);
    check("ivalid_halt_pc", op_inst_addr, 32'd4);
    check("ivalid_halt_x2", xr(2), 32'd0);

    // Reset mid-program during a store
    load_mem_prog(32'h7F);
    do_reset();
    run(1);
    reset = 1'b1;
    #1;
    check("midrst_no_wr", {31'd0, op_data_wr}, 32'd0);
    @(negedge clk);
    check("midrst_no_store", dmem[0], 32'd0);
    check("midrst_pc", op_inst_addr, 32'd0);
    for (int i = 0; i < 32; i++) check($sformatf("midrst_x%0d", i), xr(i), 32'd0);
    reset = 1'b0;
    run(5);
    check("refetch_x3", xr(3), 32'h0000007F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
